// File: rtl/fft_pkg.sv
// Shared FFT16 datapath constants: twiddle-arm multiplier coefficients (k * 2^16) and the fixed-point shift.
package fft_pkg;

  localparam int unsigned C707  = 46341;
  localparam int unsigned C541  = 35468;
  localparam int unsigned C1307 = 85627;
  localparam int unsigned FRAC  = 16;
  localparam int unsigned CW    = 18;

  // Map a CONST selector to its coefficient; unknown selectors give 0 and are rejected at elaboration.
  function automatic int unsigned const_val(input int k);
    case (k)
      707:     return C707;
      541:     return C541;
      1307:    return C1307;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/mpuc_const_mult_if.sv
// Operand/result bundle for the complex-by-constant multiplier.
interface mpuc_const_mult_if #(parameter int unsigned NB = 16);

  logic                 ED;
  logic                 DS;
  logic                 MPYJ;
  logic signed [NB-1:0] DR;
  logic signed [NB-1:0] DI;
  logic signed [NB-1:0] DOR;
  logic signed [NB-1:0] DOI;

  modport master (output ED, DS, MPYJ, DR, DI, input DOR, DOI);
  modport slave  (input ED, DS, MPYJ, DR, DI, output DOR, DOI);

endinterface

// File: rtl/mpuc_const_mult.sv
// Four-stage pipelined (DR + jDI) * C multiplier with optional -j rotation; result held between strobes.
module mpuc_const_mult
  import fft_pkg::*;
#(
  parameter int unsigned NB    = 16,
  parameter int          CONST = 707
) (
  input  logic          CLK,
  input  logic          RSTn,
  mpuc_const_mult_if.slave bus
);

  localparam int unsigned          PW = NB + CW;
  localparam logic signed [CW-1:0] CK = CW'(const_val(CONST));

  if (CONST != 707 && CONST != 541 && CONST != 1307) begin : g_bad_const
    $error("mpuc_const_mult: unsupported CONST %0d", CONST);
  end

  logic signed [NB-1:0] r1, i1;
  logic signed [PW-1:0] p2r, p2i;
  logic signed [NB-1:0] s3r, s3i;
  logic                 v1, v2, v3;
  logic                 j1, j2, j3;

  // Data path stages 1-3; everything freezes while ED is low.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r1  <= '0;
      i1  <= '0;
      p2r <= '0;
      p2i <= '0;
      s3r <= '0;
      s3i <= '0;
    end else if (bus.ED) begin
      r1  <= bus.DR;
      i1  <= bus.DI;
      p2r <= PW'(r1) * PW'(CK);
      p2i <= PW'(i1) * PW'(CK);
      s3r <= NB'(p2r >>> FRAC);
      s3i <= NB'(p2i >>> FRAC);
    end
  end

  // Valid and -j flags ride alongside the data; MPYJ only counts with a strobe.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      j1 <= 1'b0;
      j2 <= 1'b0;
      j3 <= 1'b0;
    end else if (bus.ED) begin
      v1 <= bus.DS;
      v2 <= v1;
      v3 <= v2;
      j1 <= bus.DS & bus.MPYJ;
      j2 <= j1;
      j3 <= j2;
    end
  end

  // Output register: (a + jb) * -j = b - ja; negation wraps at the most negative value.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      bus.DOR <= '0;
      bus.DOI <= '0;
    end else if (bus.ED && v3) begin
      if (j3) begin
        bus.DOR <= s3i;
        bus.DOI <= -s3r;
      end else begin
        bus.DOR <= s3r;
        bus.DOI <= s3i;
      end
    end
  end

endmodule

// File: tb/tb_mpuc_const_mult.sv
// Directed bench for mpuc_const_mult: one instance per constant, shared stimulus, hand-computed expectations.
module tb_mpuc_const_mult;

  localparam int unsigned NB = 16;

  logic                 clk;
  logic                 rst_n;
  logic                 ed, ds, mpyj;
  logic signed [NB-1:0] dr, di;

  int errors = 0;
  int checks = 0;

  mpuc_const_mult_if #(.NB(NB)) b707  ();
  mpuc_const_mult_if #(.NB(NB)) b541  ();
  mpuc_const_mult_if #(.NB(NB)) b1307 ();

  assign b707.ED   = ed;  assign b707.DS   = ds;  assign b707.MPYJ  = mpyj;
  assign b707.DR   = dr;  assign b707.DI   = di;
  assign b541.ED   = ed;  assign b541.DS   = ds;  assign b541.MPYJ  = mpyj;
  assign b541.DR   = dr;  assign b541.DI   = di;
  assign b1307.ED  = ed;  assign b1307.DS  = ds;  assign b1307.MPYJ = mpyj;
  assign b1307.DR  = dr;  assign b1307.DI  = di;

  mpuc_const_mult #(.NB(NB), .CONST(707))  u707  (.CLK(clk), .RSTn(rst_n), .bus(b707));
  mpuc_const_mult #(.NB(NB), .CONST(541))  u541  (.CLK(clk), .RSTn(rst_n), .bus(b541));
  mpuc_const_mult #(.NB(NB), .CONST(1307)) u1307 (.CLK(clk), .RSTn(rst_n), .bus(b1307));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   dr;
    int   di;
    logic mpyj;
    int   r707, i707, r541, i541, r1307, i1307;
  } vec_t;

  vec_t vecs[7];
  int   prev[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e0, input int e1, input int e2,
                           input int e3, input int e4, input int e5);
    check({tag, " 707.DOR"},  int'(b707.DOR),  e0);
    check({tag, " 707.DOI"},  int'(b707.DOI),  e1);
    check({tag, " 541.DOR"},  int'(b541.DOR),  e2);
    check({tag, " 541.DOI"},  int'(b541.DOI),  e3);
    check({tag, " 1307.DOR"}, int'(b1307.DOR), e4);
    check({tag, " 1307.DOI"}, int'(b1307.DOI), e5);
  endtask

  initial begin
    rst_n = 1'b0; ed = 1'b1; ds = 1'b0; mpyj = 1'b0; dr = '0; di = '0;

    vecs[0] = '{10000, -10000, 1'b0,   7071,  -7072,   5411,  -5412,  13065, -13066};
    vecs[1] = '{10000, -10000, 1'b1,  -7072,  -7071,  -5412,  -5411, -13066, -13065};
    vecs[2] = '{10000,      0, 1'b0,   7071,      0,   5411,      0,  13065,      0};
    vecs[3] = '{   -1,      1, 1'b0,     -1,      0,     -1,      0,     -2,      1};
    vecs[4] = '{    0, -32768, 1'b1, -23171,      0, -17734,      0,  22722,      0};
    vecs[5] = '{32767,  32767, 1'b0,  23169,  23169,  17733,  17733, -22724, -22724};
    vecs[6] = '{-25079,     0, 1'b1,      0,  17734,      0,  13573,      0, -32768};

    repeat (2) step();
    check_all("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    foreach (prev[k]) prev[k] = 0;

    // Table: one strobe per vector, output must not move at edge 3 and must update at edge 4.
    for (int v = 0; v < 7; v++) begin
      dr = NB'(vecs[v].dr); di = NB'(vecs[v].di); mpyj = vecs[v].mpyj; ds = 1'b1;
      step();
      ds = 1'b0; mpyj = 1'b1; dr = 16'sd1234; di = -16'sd4321;
      step();
      step();
      check_all($sformatf("v%0d edge3", v), prev[0], prev[1], prev[2], prev[3], prev[4], prev[5]);
      step();
      check_all($sformatf("v%0d edge4", v), vecs[v].r707, vecs[v].i707, vecs[v].r541,
                vecs[v].i541, vecs[v].r1307, vecs[v].i1307);
      prev = '{vecs[v].r707, vecs[v].i707, vecs[v].r541, vecs[v].i541, vecs[v].r1307, vecs[v].i1307};
    end

    // Hold: no strobes for 10 cycles, MPYJ toggling without DS.
    for (int c = 0; c < 10; c++) begin
      mpyj = c[0]; dr = NB'(c * 777); di = NB'(-c * 333);
      step();
    end
    check_all("hold", prev[0], prev[1], prev[2], prev[3], prev[4], prev[5]);

    // Back-to-back strobes, results on consecutive cycles.
    mpyj = 1'b0; di = '0;
    dr = 16'sd100; ds = 1'b1; step();
    dr = 16'sd200; step();
    dr = 16'sd300; step();
    ds = 1'b0; dr = '0;
    step(); check("b2b r0", int'(b707.DOR), 70);  check("b2b i0", int'(b707.DOI), 0);
    step(); check("b2b r1", int'(b707.DOR), 141);
    step(); check("b2b r2", int'(b707.DOR), 212);
    step(); check("b2b hold", int'(b707.DOR), 212);

    // ED toggling: latency counts enabled edges only; strobes while ED=0 are ignored.
    dr = 16'sd10000; di = -16'sd10000; ds = 1'b1; ed = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      ed = k[0];
      ds = ~k[0];
      dr = 16'sd555; di = 16'sd555;
      step();
    end
    check("ed before r", int'(b707.DOR), 212);
    check("ed before i", int'(b707.DOI), 0);
    ed = 1'b1; ds = 1'b0;
    step();
    check("ed result r", int'(b707.DOR), 7071);
    check("ed result i", int'(b707.DOI), -7072);
    repeat (5) step();
    check("ed after r", int'(b707.DOR), 7071);
    check("ed after i", int'(b707.DOI), -7072);

    // Reset between strobe and result: immediate clear, nothing emerges afterwards.
    dr = 16'sd300; di = 16'sd300; ds = 1'b1;
    step();
    ds = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_all("async rst", 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    repeat (6) step();
    check_all("post rst", 0, 0, 0, 0, 0, 0);
    dr = 16'sd10000; di = -16'sd10000; ds = 1'b1;
    step();
    ds = 1'b0;
    repeat (3) step();
    check_all("after rst", 7071, -7072, 5411, -5412, 13065, -13066);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
